// File: rtl/life_pkg.sv
// Shared definitions for the life sequencer: array geometry, PE command
// encodings, FSM state enum and raster scan position type.
// Geometry/encoding macros normally come from pe_decs/pe_array_decs; the
// fallbacks below match an 8x8 single-bit-state array.
`ifndef N_PX
`define N_PX 8
`endif
`ifndef N_PY
`define N_PY 8
`endif
`ifndef N_PX_BITS
`define N_PX_BITS 3
`endif
`ifndef N_PY_BITS
`define N_PY_BITS 3
`endif
`ifndef PE_CMD_BITS
`define PE_CMD_BITS 2
`endif
`ifndef PE_STATE_BITS
`define PE_STATE_BITS 1
`endif
`ifndef PE_CMD_NOP
`define PE_CMD_NOP 2'd0
`endif
`ifndef PE_CMD_LOAD
`define PE_CMD_LOAD 2'd1
`endif
`ifndef PE_CMD_STEP
`define PE_CMD_STEP 2'd2
`endif

package life_pkg;
  localparam int NPX   = `N_PX;
  localparam int NPY   = `N_PY;
  localparam int PX_W  = `N_PX_BITS;
  localparam int PY_W  = `N_PY_BITS;
  localparam int CMD_W = `PE_CMD_BITS;
  localparam int ST_W  = `PE_STATE_BITS;

  localparam logic [CMD_W-1:0] CMD_NOP  = `PE_CMD_NOP;
  localparam logic [CMD_W-1:0] CMD_LOAD = `PE_CMD_LOAD;
  localparam logic [CMD_W-1:0] CMD_STEP = `PE_CMD_STEP;

  localparam logic [PX_W-1:0] PX_LAST = PX_W'(NPX - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(NPY - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} life_state_e;

  typedef struct packed {
    logic [PY_W-1:0] y;
    logic [PX_W-1:0] x;
  } scan_t;
endpackage

// File: rtl/life_scan_ctr.sv
// Raster scan counter: x inner, y outer. Wraps to (0,0) after the last cell
// so the next phase starts from the origin without an explicit clear.
module life_scan_ctr
  import life_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_reset,
  input  logic  i_clr,
  input  logic  i_inc,
  output scan_t o_pos,
  output logic  o_last
);
  scan_t r_pos;

  // Position register; clear wins over increment
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_pos <= '0;
    end else if (i_inc) begin
      if (r_pos.x == PX_LAST) begin
        r_pos.x <= '0;
        r_pos.y <= (r_pos.y == PY_LAST) ? '0 : r_pos.y + 1'b1;
      end else begin
        r_pos.x <= r_pos.x + 1'b1;
      end
    end
  end

  assign o_pos  = r_pos;
  assign o_last = (r_pos.x == PX_LAST) && (r_pos.y == PY_LAST);
endmodule

// File: rtl/life_seq_ctrl.sv
// Job sequencer in front of pe_array: load seed board, issue STEP commands,
// drain final board. One scan counter serves both LOAD and DRAIN.
// Optional: LIFE_EARLY_STOP_EN ends RUN as soon as a STEP leaves the board
// unchanged (i_active low in the cycle after the STEP).
module life_seq_ctrl
  import life_pkg::*;
#(
  parameter int GEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [GEN_W-1:0] i_gens,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [ST_W-1:0]  i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ST_W-1:0]  o_out_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [GEN_W-1:0] o_gens_run,
  output logic [CMD_W-1:0] o_cmd,
  output logic [ST_W-1:0]  o_state_in,
  output logic [PX_W-1:0]  o_adr_x_i,
  output logic [PY_W-1:0]  o_adr_y_i,
  output logic [PX_W-1:0]  o_adr_x_o,
  output logic [PY_W-1:0]  o_adr_y_o,
  input  logic [ST_W-1:0]  i_state_out,
  input  logic             i_active
);
  life_state_e      r_state, w_next;
  logic [GEN_W-1:0] r_gens;
  logic [GEN_W-1:0] r_gen;
  logic [GEN_W-1:0] w_gen_nxt;
  logic             r_done;
  scan_t            w_pos;
  logic             w_last, w_clr, w_inc, w_step, w_static;

  life_scan_ctr u_scan (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_pos   (w_pos),
    .o_last  (w_last)
  );

  assign w_gen_nxt = r_gen + 1'b1;

`ifdef LIFE_EARLY_STOP_EN
  logic r_stepped;

  // Remember a STEP was issued so the next cycle's i_active reflects it
  always_ff @(posedge i_clk) begin
    if (i_reset) r_stepped <= 1'b0;
    else         r_stepped <= w_step;
  end

  assign w_static = r_stepped && !i_active;
`else
  logic w_active_unused;
  assign w_active_unused = i_active;
  assign w_static        = 1'b0;
`endif

  // Next-state and all datapath outputs, decoded from the current state
  always_comb begin
    w_next      = r_state;
    o_cmd       = CMD_NOP;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_state_in  = '0;
    o_out_data  = '0;
    o_adr_x_i   = '0;
    o_adr_y_i   = '0;
    o_adr_x_o   = '0;
    o_adr_y_o   = '0;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clr  = 1'b1;
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        o_in_ready = 1'b1;
        o_adr_x_i  = w_pos.x;
        o_adr_y_i  = w_pos.y;
        o_state_in = i_in_data;
        if (i_in_valid) begin
          o_cmd = CMD_LOAD;
          w_inc = 1'b1;
          if (w_last) w_next = (r_gens != '0) ? S_RUN : S_DRAIN;
        end
      end
      S_RUN: begin
        if (w_static) begin
          w_next = S_DRAIN;
        end else begin
          w_step = 1'b1;
          o_cmd  = CMD_STEP;
          if (w_gen_nxt == r_gens) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_out_valid = 1'b1;
        o_adr_x_o   = w_pos.x;
        o_adr_y_o   = w_pos.y;
        o_out_data  = i_state_out;
        if (i_out_ready) begin
          w_inc = 1'b1;
          if (w_last) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, captured generation target, issued-step count and done pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_gens  <= '0;
      r_gen   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DRAIN) && i_out_ready && w_last;
      if (r_state == S_IDLE && i_start) begin
        r_gens <= i_gens;
        r_gen  <= '0;
      end else if (w_step) begin
        r_gen <= w_gen_nxt;
      end
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_gens_run = r_gen;
endmodule

// File: tb/tb_life_seq_ctrl.sv
// Bench for life_seq_ctrl: behavioural 8x8 PE array with dead borders,
// golden Life stepping, randomized handshake gaps and seeds.
module tb_life_seq_ctrl;
  import life_pkg::*;

  localparam int NC = NPX * NPY;
`ifdef LIFE_EARLY_STOP_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [15:0] gens;
  logic [ST_W-1:0] in_data, out_data, state_in, state_out;
  logic in_ready, out_valid, busy, done, active;
  logic [15:0] gens_run;
  logic [CMD_W-1:0] cmd;
  logic [PX_W-1:0] adr_x_i, adr_x_o;
  logic [PY_W-1:0] adr_y_i, adr_y_o;

  int tests = 0, fails = 0;
  int step_cnt = 0, done_cnt = 0, stall_err = 0;
  bit out_q[$];
  logic [NC-1:0] pe_board = '0;
  logic pe_active = 1'b0;
  bit prev_stall = 0;
  logic [ST_W-1:0] prev_data = '0;

  always #5 clk = ~clk;

  life_seq_ctrl #(.GEN_W(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_gens(gens),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_busy(busy), .o_done(done), .o_gens_run(gens_run), .o_cmd(cmd),
    .o_state_in(state_in), .o_adr_x_i(adr_x_i), .o_adr_y_i(adr_y_i),
    .o_adr_x_o(adr_x_o), .o_adr_y_o(adr_y_o), .i_state_out(state_out),
    .i_active(active)
  );

  function automatic logic [NC-1:0] life_next(input logic [NC-1:0] b);
    logic [NC-1:0] r;
    r = '0;
    for (int y = 0; y < NPY; y++)
      for (int x = 0; x < NPX; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && x+dx >= 0 && x+dx < NPX && y+dy >= 0 && y+dy < NPY)
              n += int'(b[(y+dy)*NPX + x+dx]);
        r[y*NPX+x] = (n == 3) || (b[y*NPX+x] && n == 2);
      end
    return r;
  endfunction

  // Reference: steps issued and final board for a job
  task automatic golden(input logic [NC-1:0] seed, input int g, output logic [NC-1:0] fin, output int runs);
    logic [NC-1:0] b, nb;
    b = seed; runs = 0;
    for (int k = 0; k < g; k++) begin
      nb = life_next(b);
      runs++;
      if (EN && nb == b) break;
      b = nb;
    end
    fin = b;
  endtask

  // PE array model: combinational read port, registered load/step/activity
  assign state_out = ST_W'(pe_board[int'(adr_y_o)*NPX + int'(adr_x_o)]);
  assign active    = pe_active;

  always @(posedge clk) begin
    if (cmd == CMD_LOAD) pe_board[int'(adr_y_i)*NPX + int'(adr_x_i)] <= state_in[0];
    else if (cmd == CMD_STEP) begin
      pe_board  <= life_next(pe_board);
      pe_active <= (life_next(pe_board) != pe_board);
      step_cnt++;
    end
    if (out_valid && out_ready) out_q.push_back(out_data[0]);
    if (done) done_cnt++;
    if (prev_stall && out_valid && out_data !== prev_data) stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  // Run one job; aborts (returning with ok=0) at given in/out beat counts
  task automatic drive_job(input logic [NC-1:0] seed, input int g, input int vpct, input int rpct,
                           input int abort_in, input int abort_out, input bit poke, output bit ok);
    int ptr, cyc, d0;
    bit poked, hs;
    ptr = 0; cyc = 0; poked = 0; ok = 0;
    out_q.delete(); stall_err = 0; d0 = done_cnt;
    @(negedge clk); start = 1'b1; gens = 16'(g);
    @(negedge clk); start = 1'b0;
    while (cyc < 5000) begin
      if (done_cnt != d0) begin ok = 1; break; end
      if (abort_in >= 0 && ptr == abort_in) break;
      if (abort_out >= 0 && out_q.size() == abort_out) break;
      in_valid  = (ptr < NC) && ($urandom_range(99) < vpct);
      in_data   = in_valid ? ST_W'(seed[ptr]) : '0;
      out_ready = ($urandom_range(99) < rpct);
      start = 1'b0;
      if (poke && !poked && busy && !in_ready && !out_valid) begin
        start = 1'b1; gens = 16'(g + 7); poked = 1;
      end
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) ptr++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 0; out_ready = 0; start = 0; in_data = '0;
  endtask

  // Full job plus result checks
  task automatic job_check(input string nm, input logic [NC-1:0] seed, input int g,
                           input logic [NC-1:0] exp_b, input int exp_runs,
                           input int vpct, input int rpct, input bit poke);
    bit ok;
    int s0, d0;
    logic [NC-1:0] got;
    s0 = step_cnt; d0 = done_cnt;
    drive_job(seed, g, vpct, rpct, -1, -1, poke, ok);
    repeat (2) @(negedge clk);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s_timeout: done=%0b required 1", nm, ok); end
    tests++;
    if (out_q.size() != NC) begin fails++; $display("FAIL %s_beats: got %0d required %0d", nm, out_q.size(), NC); end
    got = '0;
    for (int i = 0; i < NC && i < out_q.size(); i++) got[i] = out_q[i];
    tests++;
    if (got !== exp_b) begin fails++; $display("FAIL %s_board: got %h required %h", nm, got, exp_b); end
    tests++;
    if (gens_run !== 16'(exp_runs)) begin fails++; $display("FAIL %s_gens_run: got %0d required %0d", nm, gens_run, exp_runs); end
    tests++;
    if (step_cnt - s0 != exp_runs) begin fails++; $display("FAIL %s_steps: got %0d required %0d", nm, step_cnt - s0, exp_runs); end
    tests++;
    if (done_cnt - d0 != 1 || done !== 1'b0) begin fails++; $display("FAIL %s_done: got %0d pulses required 1", nm, done_cnt - d0); end
    tests++;
    if (stall_err != 0) begin fails++; $display("FAIL %s_stall_stable: got %0d changes required 0", nm, stall_err); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL %s_idle: busy=%0b required 0", nm, busy); end
  endtask

  function automatic logic [NC-1:0] blinker_h();
    logic [NC-1:0] b;
    b = '0; b[3*NPX+2] = 1; b[3*NPX+3] = 1; b[3*NPX+4] = 1;
    return b;
  endfunction

  function automatic logic [NC-1:0] blinker_v();
    logic [NC-1:0] b;
    b = '0; b[2*NPX+3] = 1; b[3*NPX+3] = 1; b[4*NPX+3] = 1;
    return b;
  endfunction

  function automatic logic [NC-1:0] glider(input int ox, input int oy);
    logic [NC-1:0] b;
    b = '0;
    b[(oy+0)*NPX+ox+1] = 1; b[(oy+1)*NPX+ox+2] = 1;
    b[(oy+2)*NPX+ox+0] = 1; b[(oy+2)*NPX+ox+1] = 1; b[(oy+2)*NPX+ox+2] = 1;
    return b;
  endfunction

  task automatic test_reset();
    rst = 1; start = 0; gens = '0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, in_ready, out_valid, done} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b required 0000", {busy, in_ready, out_valid, done}); end
    tests++;
    if (cmd !== CMD_NOP) begin fails++; $display("FAIL reset_cmd: got %0d required %0d", cmd, CMD_NOP); end
    tests++;
    if ({adr_x_i, adr_y_i, adr_x_o, adr_y_o, state_in, gens_run} !== '0) begin fails++; $display("FAIL reset_outputs: got nonzero address/state/gens_run"); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_blinker();
    job_check("blinker", blinker_h(), 1, blinker_v(), 1, 100, 100, 0);
  endtask

  task automatic test_gens_zero();
    job_check("gens_zero", blinker_h(), 0, blinker_h(), 0, 100, 100, 0);
  endtask

  task automatic test_glider_gaps();
    job_check("glider", glider(0, 0), 4, glider(1, 1), 4, 55, 45, 0);
  endtask

  task automatic test_still_life();
    logic [NC-1:0] b;
    b = '0; b[3*NPX+3] = 1; b[3*NPX+4] = 1; b[4*NPX+3] = 1; b[4*NPX+4] = 1;
    job_check("still_life", b, 100, b, EN ? 1 : 100, 100, 100, 0);
  endtask

  task automatic reset_now(input string nm, input bit was_load);
    tests++;
    if (busy !== 1'b1 || (was_load ? in_ready : out_valid) !== 1'b1) begin
      fails++; $display("FAIL %s_pre_state: busy=%0b ready/valid=%0b required 1/1", nm, busy, was_load ? in_ready : out_valid);
    end
    rst = 1;
    @(negedge clk);
    tests++;
    if ({busy, in_ready, out_valid, done, cmd, adr_x_i, adr_y_i, adr_x_o, adr_y_o, state_in, gens_run} !==
        {4'b0, CMD_NOP, PX_W'(0), PY_W'(0), PX_W'(0), PY_W'(0), ST_W'(0), 16'd0}) begin
      fails++; $display("FAIL %s_after_reset: busy=%0b in_ready=%0b out_valid=%0b cmd=%0d gens_run=%0d required all reset values",
                        nm, busy, in_ready, out_valid, cmd, gens_run);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    drive_job(blinker_h(), 1, 100, 100, 20, -1, 0, ok);
    reset_now("mid_load", 1);
    job_check("after_mid_load", blinker_h(), 1, blinker_v(), 1, 100, 100, 0);
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    drive_job(glider(0, 0), 2, 100, 100, -1, 10, 0, ok);
    reset_now("mid_drain", 0);
    job_check("after_mid_drain", glider(0, 0), 4, glider(1, 1), 4, 100, 70, 0);
  endtask

  task automatic test_start_in_run();
    logic [NC-1:0] fin;
    int runs;
    golden(glider(0, 0), 12, fin, runs);
    job_check("start_in_run", glider(0, 0), 12, fin, runs, 100, 100, 1);
  endtask

  task automatic test_random();
    logic [NC-1:0] seed, fin;
    int g, runs;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NC; i++) seed[i] = ($urandom_range(2) == 0);
      g = $urandom_range(6);
      golden(seed, g, fin, runs);
      job_check($sformatf("random%0d", k), seed, g, fin, runs, 70, 60, 0);
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_gens_zero();
    test_glider_gaps();
    test_still_life();
    test_reset_mid_load();
    test_reset_mid_drain();
    test_start_in_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
